ntt_address_sequencer: RTL and testbench
========================================

NTT_ADDRESS_SEQUENCER -- requirements
Module: ntt_address_sequencer

Interface
REQ-001 SHALL have parameter LOG_N, default 8: log2 of transform size N; legal range 2..12.
REQ-002 SHALL have parameter STAGE_GAP, default 0: idle cycles inserted between stages for butterfly pipeline drain; legal range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: begin a transform; accepted only in IDLE.
REQ-006 SHALL have port mode, input, 1: 0 = forward (DIF, span halving); 1 = inverse (DIT, span doubling); sampled when start is accepted.
REQ-007 SHALL have port out_ready, input, 1: downstream accepts the current beat.
REQ-008 SHALL have port out_valid, output, 1: addr_a, addr_b, twiddle_addr, stage and stage_last are valid.
REQ-009 SHALL have ports addr_a and addr_b, output, LOG_N each: butterfly operand addresses.
REQ-010 SHALL have port twiddle_addr, output, LOG_N-1: twiddle ROM index (natural-order exponent).
REQ-011 SHALL have port stage, output, $clog2(LOG_N): current stage index s.
REQ-012 SHALL have ports stage_last, busy and done, output, 1 each: stage_last marks the final beat of a stage; busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> (GAP -> RUN)* -> FIN -> IDLE.
- IDLE -> RUN on start.
- RUN -> GAP after the last beat of a non-final stage when STAGE_GAP > 0; RUN -> RUN (next stage) when STAGE_GAP = 0.
- RUN -> FIN after the last beat of the final stage.
- GAP -> RUN after exactly STAGE_GAP cycles.
- FIN -> IDLE unconditionally.
REQ-014 SHALL use butterfly counter j = 0..N/2-1 per stage and stage s = 0..LOG_N-1, both zeroed on entry to RUN from IDLE.
REQ-015 SHALL, in forward mode, use span t = N>>(s+1), k = j mod t, g = j div t, addr_a = 2*g*t + k, addr_b = addr_a + t, twiddle_addr = k<<s.
REQ-016 SHALL, in inverse mode, use t = 1<<s with the same k, g, addr_a and addr_b formulas, and twiddle_addr = k<<(LOG_N-1-s).
REQ-017 SHALL register all outputs; first beat has out_valid=1 the cycle after start is sampled.
REQ-018 SHALL treat a beat as transferred when out_valid & out_ready; while out_ready=0, all outputs hold stable and counters freeze.
REQ-019 SHALL hold out_valid=0 in IDLE, GAP and FIN.
REQ-020 SHALL assert stage_last with the beat j = N/2-1.
REQ-021 SHALL pulse done for exactly one cycle in FIN, the cycle after the final beat transfers.
REQ-022 SHALL take LOG_N*N/2 + (LOG_N-1)*STAGE_GAP + 2 cycles from start to done inclusive, with out_ready held at 1.
REQ-023 SHALL ignore start while busy; mode changes after acceptance have no effect.
REQ-024 SHALL wrap j to 0 and increment s on a stage_last transfer; s never exceeds LOG_N-1.
REQ-025 SHALL accept start in the cycle FIN returns to IDLE only on the following cycle (no back-to-back start in FIN).

Reset
REQ-026 SHALL, on rst asserted at any time including mid-transform, enter IDLE immediately and zero all outputs, j, s, the gap counter and the latched mode.
REQ-027 SHALL accept start the first clock edge after rst deasserts.

Structure
REQ-028 SHALL declare the FSM state enum, the mode encoding (MODE_FWD=0, MODE_INV=1) and the LOG_N default in the shared package ntt_pkg.
REQ-029 SHALL place the (j, s, mode) -> (addr_a, addr_b, twiddle_addr) mapping in the combinational sub-module ntt_butterfly_map; the FSM, counters and output registers stay in the top level.

Verification
REQ-030 SHALL cover forward mode, LOG_N=3, STAGE_GAP=0, ready=1:
- s0 beats (a,b,tw): (0,4,0) (1,5,1) (2,6,2) (3,7,3).
- s1 beats: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
- s2 beats: (0,1,0) (2,3,0) (4,5,0) (6,7,0).
- done at cycle 14.
REQ-031 SHALL cover inverse mode, LOG_N=3: s0 gives pairs (0,1) (2,3) (4,5) (6,7) with tw=0; s2 gives (0,4,0) (1,5,1) (2,6,2) (3,7,3).
REQ-032 SHALL cover backpressure: out_ready toggled pseudo-randomly, so beats match REQ-030 exactly, outputs are stable while stalled, and there are no duplicate or lost beats.
REQ-033 SHALL cover STAGE_GAP=3, LOG_N=3: exactly 3 cycles with out_valid=0 between stages, and done at cycle 20.
REQ-034 SHALL cover rst asserted mid-stage 1: outputs zero at once; a new start restarts at s0 j0; a start issued while busy is ignored.

Source files
------------

// File: rtl/ntt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ntt_pkg : shared types and constants for the NTT address path    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ntt_pkg;

   localparam int   LOG_N_DEFAULT = 8;
   localparam logic MODE_FWD      = 1'b0;
   localparam logic MODE_INV      = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/ntt_butterfly_map.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ntt_butterfly_map : (j, s, mode) -> operand/twiddle addresses    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ntt_butterfly_map
   import ntt_pkg::*;
#(
   parameter int LOG_N = LOG_N_DEFAULT,
   parameter int SW    = $clog2(LOG_N)
)(
   input  logic [LOG_N-2:0] j_i,
   input  logic [SW-1:0]    s_i,
   input  logic             mode_i,
   output logic [LOG_N-1:0] addr_a_o,
   output logic [LOG_N-1:0] addr_b_o,
   output logic [LOG_N-2:0] twiddle_o
);

   localparam logic [SW-1:0] c_s_max = SW'(LOG_N - 1);

   logic [SW-1:0]    w_sh_span;
   logic [SW-1:0]    w_sh_tw;
   logic [LOG_N-1:0] w_j;
   logic [LOG_N-1:0] w_span;
   logic [LOG_N-1:0] w_k;
   logic [LOG_N-1:0] w_g;

   // Span and twiddle shifts are complementary: log2(t) + tw_shift = LOG_N-1.
   always_comb begin
      w_sh_span = (mode_i == MODE_INV) ? s_i : c_s_max - s_i;
      w_sh_tw   = (mode_i == MODE_INV) ? c_s_max - s_i : s_i;
      w_j       = {1'b0, j_i};
      w_span    = LOG_N'(1) << w_sh_span;
      w_k       = w_j & (w_span - LOG_N'(1));
      w_g       = w_j >> w_sh_span;
      addr_a_o  = ((w_g << w_sh_span) << 1) | w_k;
      addr_b_o  = addr_a_o | w_span;
      twiddle_o = w_k[LOG_N-2:0] << w_sh_tw;
   end

endmodule
`default_nettype wire

// File: rtl/ntt_address_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ntt_address_sequencer : butterfly address/twiddle beat generator |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ntt_address_sequencer
   import ntt_pkg::*;
#(
   parameter int LOG_N     = LOG_N_DEFAULT,
   parameter int STAGE_GAP = 0
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     mode,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [LOG_N-1:0]         addr_a,
   output logic [LOG_N-1:0]         addr_b,
   output logic [LOG_N-2:0]         twiddle_addr,
   output logic [$clog2(LOG_N)-1:0] stage,
   output logic                     stage_last,
   output logic                     busy,
   output logic                     done
);

   localparam int             SW         = $clog2(LOG_N);
   localparam int             HW         = LOG_N - 1;
   localparam logic [HW-1:0]  c_j_last   = '1;
   localparam logic [SW-1:0]  c_s_last   = SW'(LOG_N - 1);
   localparam logic [3:0]     c_gap_last = (STAGE_GAP > 0) ? 4'(STAGE_GAP - 1) : 4'd0;

   state_e        state_q, state_d;
   logic [HW-1:0] j_q, j_d;
   logic [SW-1:0] s_q, s_d;
   logic [3:0]    gap_q, gap_d;
   logic          mode_q, mode_d;
   logic          valid_d;
   logic          done_d;

   logic [LOG_N-1:0] w_addr_a;
   logic [LOG_N-1:0] w_addr_b;
   logic [HW-1:0]    w_twiddle;

   // Output registers load from next-state counters so every port is registered.
   ntt_butterfly_map #(
      .LOG_N (LOG_N),
      .SW    (SW)
   ) u_map (
      .j_i       (j_d),
      .s_i       (s_d),
      .mode_i    (mode_d),
      .addr_a_o  (w_addr_a),
      .addr_b_o  (w_addr_b),
      .twiddle_o (w_twiddle)
   );

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      s_d     = s_q;
      gap_d   = gap_q;
      mode_d  = mode_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               j_d     = '0;
               s_d     = '0;
               gap_d   = '0;
               mode_d  = mode;
               valid_d = 1'b1;
            end
         end
         ST_RUN: begin
            valid_d = 1'b1;
            if (out_ready) begin
               if (j_q != c_j_last) begin
                  j_d = j_q + HW'(1);
               end else if (s_q == c_s_last) begin
                  state_d = ST_FIN;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  j_d = '0;
                  s_d = s_q + SW'(1);
                  if (STAGE_GAP > 0) begin
                     state_d = ST_GAP;
                     gap_d   = '0;
                     valid_d = 1'b0;
                  end
               end
            end
         end
         ST_GAP: begin
            if (gap_q == c_gap_last) begin
               state_d = ST_RUN;
               gap_d   = '0;
               valid_d = 1'b1;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         j_q          <= '0;
         s_q          <= '0;
         gap_q        <= '0;
         mode_q       <= MODE_FWD;
         out_valid    <= 1'b0;
         addr_a       <= '0;
         addr_b       <= '0;
         twiddle_addr <= '0;
         stage        <= '0;
         stage_last   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         j_q          <= j_d;
         s_q          <= s_d;
         gap_q        <= gap_d;
         mode_q       <= mode_d;
         out_valid    <= valid_d;
         addr_a       <= valid_d ? w_addr_a  : '0;
         addr_b       <= valid_d ? w_addr_b  : '0;
         twiddle_addr <= valid_d ? w_twiddle : '0;
         stage        <= valid_d ? s_d       : '0;
         stage_last   <= valid_d && (j_d == c_j_last);
         busy         <= (state_d != ST_IDLE);
         done         <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ntt_address_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ntt_address_sequencer : two instances (gap 0 / gap 3), LOG_N=3 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ntt_address_sequencer;
   import ntt_pkg::*;

   localparam int L     = 3;
   localparam int N     = 1 << L;
   localparam int HALF  = N / 2;
   localparam int TOTAL = L * HALF;
   localparam int G1    = 3;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic mode;
   logic out_ready;

   logic           v_w    [2];
   logic [L-1:0]   a_w    [2];
   logic [L-1:0]   b_w    [2];
   logic [L-2:0]   tw_w   [2];
   logic [1:0]     st_w   [2];
   logic           last_w [2];
   logic           busy_w [2];
   logic           done_w [2];

   int n_chk  = 0;
   int n_pass = 0;

   int exp_a [TOTAL];
   int exp_b [TOTAL];
   int exp_tw[TOTAL];
   int exp_s [TOTAL];
   int exp_l [TOTAL];

   int          idx     [2];
   int          done_cyc[2];
   int          gaprun  [2];
   bit          stalled [2];
   logic [11:0] prev    [2];
   int          gap_exp [2] = '{0, G1};

   always #5 clk = ~clk;

   ntt_address_sequencer #(.LOG_N(L), .STAGE_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .out_ready(out_ready),
      .out_valid(v_w[0]), .addr_a(a_w[0]), .addr_b(b_w[0]), .twiddle_addr(tw_w[0]),
      .stage(st_w[0]), .stage_last(last_w[0]), .busy(busy_w[0]), .done(done_w[0])
   );

   ntt_address_sequencer #(.LOG_N(L), .STAGE_GAP(G1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .out_ready(out_ready),
      .out_valid(v_w[1]), .addr_a(a_w[1]), .addr_b(b_w[1]), .twiddle_addr(tw_w[1]),
      .stage(st_w[1]), .stage_last(last_w[1]), .busy(busy_w[1]), .done(done_w[1])
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Expected beat list straight from the span/group arithmetic.
   task automatic build_model(input logic m);
      int n, t, k, g;
      n = 0;
      for (int s = 0; s < L; s++) begin
         for (int j = 0; j < HALF; j++) begin
            t = (m == MODE_FWD) ? (N >> (s + 1)) : (1 << s);
            k = j % t;
            g = j / t;
            exp_a[n]  = 2 * g * t + k;
            exp_b[n]  = 2 * g * t + k + t;
            exp_tw[n] = (m == MODE_FWD) ? (k << s) : (k << (L - 1 - s));
            exp_s[n]  = s;
            exp_l[n]  = (j == HALF - 1) ? 1 : 0;
            n++;
         end
      end
   endtask

   task automatic observe(input int id, input int c, input bit timed);
      logic [11:0] snap;
      int          n;
      snap = {v_w[id], last_w[id], st_w[id], tw_w[id], b_w[id], a_w[id]};
      if (stalled[id]) check_eq($sformatf("hold%0d", id), int'(snap), int'(prev[id]));
      if (done_cyc[id] < 0 && c >= 2) check_eq($sformatf("busy%0d", id), int'(busy_w[id]), 1);
      if (v_w[id]) begin
         if (timed && idx[id] > 0 && idx[id] % HALF == 0) begin
            check_eq($sformatf("gap%0d", id), gaprun[id], gap_exp[id]);
            gaprun[id] = 0;
         end
      end else if (busy_w[id] && !done_w[id] && idx[id] > 0) begin
         gaprun[id]++;
      end
      if (v_w[id] && out_ready) begin
         n = idx[id];
         if (n < TOTAL) begin
            check_eq($sformatf("a%0d[%0d]", id, n),  int'(a_w[id]),    exp_a[n]);
            check_eq($sformatf("b%0d[%0d]", id, n),  int'(b_w[id]),    exp_b[n]);
            check_eq($sformatf("tw%0d[%0d]", id, n), int'(tw_w[id]),   exp_tw[n]);
            check_eq($sformatf("s%0d[%0d]", id, n),  int'(st_w[id]),   exp_s[n]);
            check_eq($sformatf("sl%0d[%0d]", id, n), int'(last_w[id]), exp_l[n]);
         end else begin
            check_eq($sformatf("extra_beat%0d", id), n, TOTAL - 1);
         end
         idx[id]++;
      end
      stalled[id] = v_w[id] && !out_ready;
      prev[id]    = snap;
      if (done_w[id]) begin
         if (done_cyc[id] < 0) begin
            done_cyc[id] = c;
            check_eq($sformatf("beats_at_done%0d", id), idx[id], TOTAL);
            if (timed)
               check_eq($sformatf("done_cycle%0d", id), c, TOTAL + (L - 1) * gap_exp[id] + 2);
         end else begin
            check_eq($sformatf("done_width%0d", id), c, done_cyc[id]);
         end
      end else if (done_cyc[id] >= 0 && c == done_cyc[id] + 1) begin
         check_eq($sformatf("idle_busy%0d", id), int'(busy_w[id]), 0);
      end
   endtask

   // Cycle 1 is the cycle in which start is presented.
   task automatic run(input logic m, input bit rnd);
      int c;
      bit fin;
      build_model(m);
      for (int i = 0; i < 2; i++) begin
         idx[i] = 0; done_cyc[i] = -1; gaprun[i] = 0; stalled[i] = 0;
      end
      start     = 1'b1;
      mode      = m;
      out_ready = 1'b1;
      c   = 1;
      fin = 0;
      while (!fin && c < 400) begin
         @(posedge clk); #1;
         c++;
         mode      = ~m;
         start     = busy_w[0] && busy_w[1] && ($urandom_range(0, 3) == 0);
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         observe(0, c, !rnd);
         observe(1, c, !rnd);
         fin = done_cyc[0] >= 0 && done_cyc[1] >= 0 &&
               c > done_cyc[0] + 1 && c > done_cyc[1] + 1;
      end
      for (int i = 0; i < 2; i++)
         check_eq($sformatf("done_seen%0d", i), int'(done_cyc[i] >= 0), 1);
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("%s_out%0d", tag, i),
                  int'({v_w[i], last_w[i], st_w[i], tw_w[i], b_w[i], a_w[i]}), 0);
         check_eq($sformatf("%s_busy%0d", tag, i), int'({busy_w[i], done_w[i]}), 0);
      end
   endtask

   initial begin
      int k;
      rst       = 1'b1;
      start     = 1'b0;
      mode      = MODE_FWD;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      run(MODE_FWD, 0);
      run(MODE_INV, 0);
      run(MODE_FWD, 1);
      run(MODE_INV, 1);
      repeat (2) run(logic'($urandom_range(0, 1)), 1);

      // Reset in the middle of stage 1, then restart from scratch.
      start = 1'b1;
      mode  = MODE_FWD;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!(v_w[0] && st_w[0] == 2'd1) && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq("reached_s1", int'(st_w[0]), 1);
      #2 rst = 1'b1;
      #1;
      check_zero("midrst");
      #2 rst = 1'b0;
      run(MODE_FWD, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
